pipeline_hazard_ctrl: RTL

Central sequencing controller for the 5-stage pipelined CPU datapath.
- Drives the datapath control inputs: enablePC, IF/ID hold, Flush1/Flush2/Flush3, imJumpFlag/imJump.
- Inserts load-use stall bubbles, redirects and flushes on a taken branch resolved in EX, and handles boot and HALT drain.
- Maintains saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencing controller.
// Imported by the hazard controller and the load-use detector.
package cpu_ctrl_pkg;

    localparam int REG_W = 3;
    localparam int PC_W  = 16;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        STALL,
        DRAIN,
        HALTED
    } ctrl_state_t;

    // Remaining bubbles after the first hazard cycle (LOAD_STALL is 1..3).
    typedef logic [1:0] stall_rem_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: EX load writing a register ID reads.
// R0 is a real register, so index 0 is compared like any other.
module load_use_detect #(
    parameter int REG_W = cpu_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hazard
);

    logic hit1;
    logic hit2;

    assign hit1   = id_use_rs1 && (id_rs1 == ex_rd);
    assign hit2   = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard = ex_mem_read && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: boot, load-use stalls, branch redirect,
// HALT drain, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = cpu_ctrl_pkg::REG_W,
    parameter int PC_W        = cpu_ctrl_pkg::PC_W,
    parameter int BOOT_CYCLES = 2,
    parameter int LOAD_STALL  = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic [PC_W-1:0]  ex_branch_target,
    input  logic             wb_halt,
    output logic             enablePC,
    output logic             ifid_hold,
    output logic             Flush1,
    output logic             Flush2,
    output logic             Flush3,
    output logic             imJumpFlag,
    output logic [PC_W-1:0]  imJump,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import cpu_ctrl_pkg::*;

    localparam int BCW =
        (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST =
        (BOOT_CYCLES > 1) ? BCW'(BOOT_CYCLES - 1) : '0;
    localparam stall_rem_t STALL_INIT =
        stall_rem_t'((LOAD_STALL > 1) ? LOAD_STALL - 1 : 0);

    ctrl_state_t    state;
    ctrl_state_t    state_nx;
    logic [BCW-1:0] boot_cnt;
    logic [BCW-1:0] boot_cnt_nx;
    stall_rem_t     rem;
    stall_rem_t     rem_nx;
    logic           hazard;
    logic           stall_inc;
    logic           flush_inc;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_lud (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .hazard     (hazard)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            boot_cnt <= '0;
            rem      <= '0;
        end else begin
            state    <= state_nx;
            boot_cnt <= boot_cnt_nx;
            rem      <= rem_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        boot_cnt_nx = boot_cnt;
        rem_nx      = rem;
        enablePC    = 1'b0;
        ifid_hold   = 1'b0;
        Flush1      = 1'b0;
        Flush2      = 1'b0;
        Flush3      = 1'b0;
        imJumpFlag  = 1'b0;
        imJump      = '0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state)
            BOOT: begin
                Flush1 = 1'b1;
                Flush2 = 1'b1;
                Flush3 = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_nx = RUN;
                end else begin
                    boot_cnt_nx = boot_cnt + 1'b1;
                end
            end
            RUN: begin
                // Branch beats hazard and squashes a younger HALT.
                if (ex_branch_taken) begin
                    imJumpFlag = 1'b1;
                    imJump     = ex_branch_target;
                    enablePC   = 1'b1;
                    Flush1     = 1'b1;
                    Flush2     = 1'b1;
                    flush_inc  = 1'b1;
                end else if (hazard) begin
                    ifid_hold = 1'b1;
                    Flush2    = 1'b1;
                    stall_inc = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nx = STALL;
                        rem_nx   = STALL_INIT;
                    end
                end else if (id_halt) begin
                    Flush1   = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    enablePC = 1'b1;
                end
            end
            STALL: begin
                ifid_hold = 1'b1;
                Flush2    = 1'b1;
                stall_inc = 1'b1;
                rem_nx    = rem - 1'b1;
                if (rem <= 2'd1) begin
                    state_nx = RUN;
                end
            end
            DRAIN: begin
                Flush1 = 1'b1;
                if (wb_halt) begin
                    state_nx = HALTED;
                end
            end
            HALTED: begin
                Flush1 = 1'b1;
                halted = 1'b1;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
